// File: rtl/sar_seq_pkg.sv
// sar_seq_pkg -- shared definitions for the SAR conversion sequencer.
//   - sar_state_e : sequencer states (IDLE, SAMPLE, COMP, DONE)
//   - legal ranges and defaults for NBITS / SAMPLE_CYC
//   - CNT_W       : sample counter width, sized for the largest legal SAMPLE_CYC
//   - idx_w()     : width of the bit-index bus for a given conversion width
package sar_seq_pkg;

  localparam int NBITS_DEF      = 8;
  localparam int NBITS_MIN      = 2;
  localparam int NBITS_MAX      = 16;
  localparam int SAMPLE_CYC_DEF = 2;
  localparam int SAMPLE_CYC_MIN = 1;
  localparam int SAMPLE_CYC_MAX = 15;

  // Sample counter counts 0..SAMPLE_CYC-1, so the largest legal value fits.
  localparam int CNT_W = $clog2(SAMPLE_CYC_MAX + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    COMP   = 2'd2,
    DONE   = 2'd3
  } sar_state_e;

  function automatic int idx_w(input int nbits);
    return $clog2(nbits);
  endfunction

endpackage

// File: rtl/sar_reg.sv
// sar_reg -- successive-approximation trial word register.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (word cleared)
//   init       : load the mid-scale trial word 1<<(NBITS-1)
//   step       : apply the comparator decision for bit[bit_idx] and, if a
//                lower bit exists, raise bit[bit_idx-1] as the next trial
//   comp_in    : comparator decision (1 = keep bit[bit_idx])
//   bit_idx    : bit under trial
//   word       : registered trial word (drives the DAC)
//   word_nxt   : value the word takes at the next edge (used to capture the
//                final result on the bit 0 decision)
module sar_reg
  import sar_seq_pkg::*;
#(
  parameter int NBITS = NBITS_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     init,
  input  logic                     step,
  input  logic                     comp_in,
  input  logic [$clog2(NBITS)-1:0] bit_idx,
  output logic [NBITS-1:0]         word,
  output logic [NBITS-1:0]         word_nxt
);

  localparam int IDX_W = idx_w(NBITS);
  localparam logic [NBITS-1:0] INIT_WORD = {1'b1, {(NBITS-1){1'b0}}};
  localparam logic [NBITS-1:0] ONE_WORD  = {{(NBITS-1){1'b0}}, 1'b1};

  logic [NBITS-1:0] word_r;
  logic [NBITS-1:0] word_s;
  logic [NBITS-1:0] trial_s;
  logic [IDX_W-1:0] idx_lo_s;

  // Next trial word: init loads mid-scale, step resolves one bit and opens the next trial.
  always_comb begin
    word_s   = word_r;
    idx_lo_s = bit_idx - IDX_W'(1);
    // No lower bit to try once bit 0 is being decided.
    trial_s  = (bit_idx != '0) ? (ONE_WORD << idx_lo_s) : '0;
    if (init) begin
      word_s = INIT_WORD;
    end else if (step) begin
      word_s[bit_idx] = comp_in;
      word_s          = word_s | trial_s;
    end else begin
      word_s = word_r;
    end
  end

  // Trial word register.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_r <= '0;
    end else begin
      word_r <= word_s;
    end
  end

  assign word     = word_r;
  assign word_nxt = word_s;

endmodule

// File: rtl/sar_seq_chk.sv
// sar_seq_chk -- property checker for the sar_seq clock-gate enables.
// Ports:
//   clk       : sequencer clock
//   en_sample : sampling-switch gate enable under check
//   en_comp   : comparator gate enable under check
// The enables must never overlap, and must not move between the falling
// edge and the next rising edge (they may only change at the rising edge).
module sar_seq_chk (
  input logic clk,
  input logic en_sample,
  input logic en_comp
);

  logic mid_valid_r;
  logic samp_mid_r;
  logic comp_mid_r;

  // Capture the enables mid-cycle for comparison at the following rising edge.
  always_ff @(negedge clk) begin
    mid_valid_r <= 1'b1;
    samp_mid_r  <= en_sample;
    comp_mid_r  <= en_comp;
  end

  a_excl_pos: assert property (@(posedge clk) !(en_sample && en_comp));
  a_excl_neg: assert property (@(negedge clk) !(en_sample && en_comp));
  a_samp_quiet: assert property (@(posedge clk) mid_valid_r |-> (en_sample == samp_mid_r));
  a_comp_quiet: assert property (@(posedge clk) mid_valid_r |-> (en_comp == comp_mid_r));

endmodule

// File: rtl/sar_seq.sv
// sar_seq -- SAR ADC conversion sequencer (IDLE -> SAMPLE -> COMP -> DONE).
// Ports:
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   start      : conversion request, honoured only in IDLE (and in DONE when
//                back-to-back conversions are enabled)
//   comp_in    : comparator decision for the current trial (1 = keep bit)
//   en_sample  : sampling-switch clock-gate enable, high SAMPLE_CYC cycles
//   en_comp    : comparator clock-gate enable, high NBITS cycles
//   dac_state  : current SAR trial word driving the DAC
//   bit_idx    : index of the bit under trial
//   busy       : high whenever the sequencer is not idle
//   done       : one-cycle pulse coinciding with the result update
//   result     : last completed conversion, held until the next done
// Build option:
//   SAR_SEQ_CONT_EN : when defined, a start seen in the DONE cycle goes
//                     straight back to SAMPLE (period SAMPLE_CYC+NBITS+1);
//                     otherwise DONE always returns to IDLE.
// All outputs come straight from flops so the gate enables are glitch-free.
module sar_seq
  import sar_seq_pkg::*;
#(
  parameter int NBITS      = NBITS_DEF,
  parameter int SAMPLE_CYC = SAMPLE_CYC_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     comp_in,
  output logic                     en_sample,
  output logic                     en_comp,
  output logic [NBITS-1:0]         dac_state,
  output logic [$clog2(NBITS)-1:0] bit_idx,
  output logic                     busy,
  output logic                     done,
  output logic [NBITS-1:0]         result
);

  localparam int IDX_W = idx_w(NBITS);
  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_TOP     = IDX_W'(NBITS - 1);

  if ((NBITS < NBITS_MIN) || (NBITS > NBITS_MAX)) begin : g_bad_nbits
    $error("sar_seq: NBITS out of legal range 2..16");
  end
  if ((SAMPLE_CYC < SAMPLE_CYC_MIN) || (SAMPLE_CYC > SAMPLE_CYC_MAX)) begin : g_bad_sample_cyc
    $error("sar_seq: SAMPLE_CYC out of legal range 1..15");
  end

  sar_state_e       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [IDX_W-1:0] idx_r;
  logic             en_sample_r;
  logic             en_comp_r;
  logic             busy_r;
  logic             done_r;
  logic [NBITS-1:0] result_r;

  logic             init_s;
  logic             step_s;
  logic             last_s;
  logic [NBITS-1:0] word_s;
  logic [NBITS-1:0] word_nxt_s;

  // Datapath controls: when to start a new trial word and when to resolve a bit.
  always_comb begin
    init_s = 1'b0;
    step_s = 1'b0;
    last_s = 1'b0;
    case (state_r)
      IDLE: init_s = start;
      COMP: begin
        step_s = 1'b1;
        last_s = (idx_r == '0);
      end
`ifdef SAR_SEQ_CONT_EN
      DONE: init_s = start;
`else
      DONE: init_s = 1'b0;
`endif
      default: init_s = 1'b0;
    endcase
  end

  // Sequencer state, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      idx_r       <= '0;
      en_sample_r <= 1'b0;
      en_comp_r   <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      result_r    <= '0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (init_s) begin
            state_r     <= SAMPLE;
            cnt_r       <= '0;
            en_sample_r <= 1'b1;
            busy_r      <= 1'b1;
          end
        end
        SAMPLE: begin
          // Enables swap on the same edge, so they are never both high.
          if (cnt_r == SAMPLE_LAST) begin
            state_r     <= COMP;
            en_sample_r <= 1'b0;
            en_comp_r   <= 1'b1;
            idx_r       <= IDX_TOP;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        COMP: begin
          if (last_s) begin
            state_r   <= DONE;
            en_comp_r <= 1'b0;
            done_r    <= 1'b1;
            result_r  <= word_nxt_s;
          end else begin
            idx_r <= idx_r - IDX_W'(1);
          end
        end
        DONE: begin
          if (init_s) begin
            state_r     <= SAMPLE;
            cnt_r       <= '0;
            en_sample_r <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          en_sample_r <= 1'b0;
          en_comp_r   <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  sar_reg #(
    .NBITS (NBITS)
  ) u_sar_reg (
    .clk      (clk),
    .rst      (rst),
    .init     (init_s),
    .step     (step_s),
    .comp_in  (comp_in),
    .bit_idx  (idx_r),
    .word     (word_s),
    .word_nxt (word_nxt_s)
  );

  assign en_sample = en_sample_r;
  assign en_comp   = en_comp_r;
  assign dac_state = word_s;
  assign bit_idx   = idx_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign result    = result_r;

endmodule

// File: tb/tb_sar_seq.sv
// tb_sar_seq -- self-checking bench for sar_seq (NBITS=8, SAMPLE_CYC=2).
// A timeline model (phase since start) predicts every output each cycle;
// directed scenarios pin that model with hand-computed literals, then
// randomized start/reset/comparator stimulus runs against it.
module tb_sar_seq;

  localparam int N       = 8;
  localparam int SC      = 2;
  localparam int IW      = $clog2(N);
  localparam int DONE_PH = SC + N + 1;
`ifdef SAR_SEQ_CONT_EN
  localparam int PERIOD = 11;
`else
  localparam int PERIOD = 12;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          comp_in;
  logic          en_sample;
  logic          en_comp;
  logic [N-1:0]  dac_state;
  logic [IW-1:0] bit_idx;
  logic          busy;
  logic          done;
  logic [N-1:0]  result;

  // Comparator model: 0 = compare against target, 1 = random, 2 = always 1, 3 = always 0
  int           mode = 0;
  logic [N-1:0] target = '0;
  logic         rnd_bit = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int s0 = 0;

  // Timeline model: m_ph = 0 idle, 1..SC sampling, SC+1..SC+N trials, DONE_PH done
  int           m_ph = 0;
  logic [N-1:0] m_dec = '0;
  logic [N-1:0] m_res = '0;
  bit           m_rst = 1'b1;
  logic [N-1:0] e_dac;
  int           b;

  // Event logs for the directed scenarios
  int           w_done_cnt = 0;
  int           w_done_cyc = 0;
  int           w_prev_done = 0;
  int           w_es_first = 0;
  int           w_es_cnt = 0;
  int           w_ec_first = 0;
  int           w_ec_cnt = 0;
  logic [N-1:0] w_dac_first = '0;

  assign comp_in = (mode == 0) ? (dac_state <= target) :
                   (mode == 1) ? rnd_bit :
                   (mode == 2);

  sar_seq #(
    .NBITS      (N),
    .SAMPLE_CYC (SC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .comp_in   (comp_in),
    .en_sample (en_sample),
    .en_comp   (en_comp),
    .dac_state (dac_state),
    .bit_idx   (bit_idx),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  sar_seq_chk u_chk (
    .clk       (clk),
    .en_sample (en_sample),
    .en_comp   (en_comp)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_win();
    w_done_cnt = 0;
    w_done_cyc = 0;
    w_prev_done = 0;
    w_es_first = 0;
    w_es_cnt = 0;
    w_ec_first = 0;
    w_ec_cnt = 0;
    w_dac_first = '0;
  endtask

  // Enables may only move at rising edges (edges sit at 5 + 10k).
  always @(en_sample or en_comp) begin
    if (($time > 0) && (($time % 10) != 5)) begin
      errors++;
      $display("FAIL glitch enable moved at time %0t", $time);
    end
  end

  // Per-cycle compare against the model, then advance the model by one edge.
  always @(negedge clk) begin
    b = SC + N - m_ph;
    if (m_ph >= 1 && m_ph <= SC) e_dac = {1'b1, {(N-1){1'b0}}};
    else if (m_ph > SC && m_ph <= SC + N) e_dac = m_dec | (N'(1) << b);
    else e_dac = m_dec;

    check("busy", busy, m_ph != 0);
    check("en_sample", en_sample, (m_ph >= 1) && (m_ph <= SC));
    check("en_comp", en_comp, (m_ph > SC) && (m_ph <= SC + N));
    check("done", done, m_ph == DONE_PH);
    check("dac_state", dac_state, e_dac);
    check("result", result, m_res);
    check("excl", en_sample & en_comp, 1'b0);
    if (m_ph > SC && m_ph <= SC + N) check("bit_idx", bit_idx, b);
    else if (m_rst) check("bit_idx_rst", bit_idx, 0);

    if (done) begin
      w_done_cnt++;
      w_prev_done = w_done_cyc;
      w_done_cyc = cyc;
    end
    if (en_sample) begin
      if (w_es_cnt == 0) w_es_first = cyc;
      w_es_cnt++;
    end
    if (en_comp) begin
      if (w_ec_cnt == 0) begin
        w_ec_first = cyc;
        w_dac_first = dac_state;
      end
      w_ec_cnt++;
    end

    if (rst) begin
      m_ph = 0;
      m_dec = '0;
      m_res = '0;
      m_rst = 1'b1;
    end else begin
      m_rst = 1'b0;
      if (m_ph == 0) begin
        if (start) begin
          m_ph = 1;
          m_dec = '0;
        end
      end else if (m_ph == DONE_PH) begin
`ifdef SAR_SEQ_CONT_EN
        if (start) begin
          m_ph = 1;
          m_dec = '0;
        end else begin
          m_ph = 0;
        end
`else
        m_ph = 0;
`endif
      end else begin
        if (m_ph > SC) m_dec = m_dec | (N'(comp_in) << b);
        if (m_ph == SC + N) m_res = m_dec;
        m_ph++;
      end
    end
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    mode = 0;
    tick(3);
    check("rst_busy", busy, 1'b0);
    check("rst_dac", dac_state, 8'h00);
    check("rst_result", result, 8'h00);
    rst = 1'b0;
    tick(2);

    // Target 0xA5 through a comparator model
    mode = 0;
    target = 8'hA5;
    clear_win();
    s0 = cyc;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(14);
    check("A_done_cnt", w_done_cnt, 1);
    check("A_done_cyc", w_done_cyc - s0, 11);
    check("A_result", result, 8'hA5);
    check("A_es_first", w_es_first - s0, 1);
    check("A_es_cnt", w_es_cnt, 2);
    check("A_ec_first", w_ec_first - s0, 3);
    check("A_ec_cnt", w_ec_cnt, 8);
    check("A_dac_first", w_dac_first, 8'h80);

    // Comparator stuck high, then stuck low
    mode = 2;
    clear_win();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(14);
    check("B_result", result, 8'hFF);
    check("B_dac_first", w_dac_first, 8'h80);
    mode = 3;
    clear_win();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(14);
    check("C_result", result, 8'h00);
    check("C_dac_first", w_dac_first, 8'h80);
    check("C_done_cnt", w_done_cnt, 1);

    // start re-pulsed in cycle 5 must be ignored
    mode = 0;
    target = 8'h5A;
    clear_win();
    s0 = cyc;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(4);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(6);
    check("D_busy_c12", busy, 1'b0);
    tick(6);
    check("D_done_cnt", w_done_cnt, 1);
    check("D_result", result, 8'h5A);

    // Reset in cycle 6 aborts; new start accepted right after release
    target = 8'h3C;
    clear_win();
    s0 = cyc;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(5);
    rst = 1'b1;
    tick(1);
    check("E_en_sample", en_sample, 1'b0);
    check("E_en_comp", en_comp, 1'b0);
    check("E_busy", busy, 1'b0);
    check("E_done", done, 1'b0);
    check("E_dac", dac_state, 8'h00);
    check("E_bit_idx", bit_idx, 0);
    check("E_result", result, 8'h00);
    rst = 1'b0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(14);
    check("E_done_cnt", w_done_cnt, 1);
    check("E_done_cyc", w_done_cyc - s0, 18);
    check("E_result2", result, 8'h3C);

    // start held high: back-to-back conversion period
    target = 8'hC3;
    clear_win();
    start = 1'b1;
    tick(4 * PERIOD);
    start = 1'b0;
    tick(PERIOD + 2);
    check("F_cnt_ge3", w_done_cnt >= 3, 1'b1);
    check("F_period", w_done_cyc - w_prev_done, PERIOD);
    check("F_result", result, 8'hC3);

    // Randomized start / reset / comparator stimulus against the model
    for (int i = 0; i < 4000; i++) begin
      mode = $urandom_range(0, 3);
      target = N'($urandom);
      rnd_bit = 1'($urandom);
      start = ($urandom_range(0, 5) == 0);
      rst = ($urandom_range(0, 150) == 0);
      tick(1);
    end
    rst = 1'b0;
    start = 1'b0;
    tick(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sar_seq.md
SAR_SEQ -- requirements
Module: sar_seq

Interface
- REQ-001: The parameter NBITS SHALL default to 8 and set the conversion width; legal values are 2..16.
- REQ-002: The parameter SAMPLE_CYC SHALL default to 2 and set the number of sampling cycles; legal values are 1..15.
- REQ-003: The design SHALL use one clock and a synchronous, active-high reset: `clk` (input, 1 bit, rising-edge clock) and `rst` (input, 1 bit, synchronous active-high reset).
- REQ-004: The port `start` SHALL be an input, 1 bit, conversion request, sampled on `clk`.
- REQ-005: The port `comp_in` SHALL be an input, 1 bit: the comparator decision for the current trial (1 = keep the bit).
- REQ-006: The port `en_sample` SHALL be an output, 1 bit: the enable to the sampling-switch clock gate.
- REQ-007: The port `en_comp` SHALL be an output, 1 bit: the enable to the comparator clock gate.
- REQ-008: The port `dac_state` SHALL be an output, NBITS bits: the current SAR trial word driving the DAC.
- REQ-009: The port `bit_idx` SHALL be an output, $clog2(NBITS) bits: the index of the bit under trial.
- REQ-010: The port `busy` SHALL be an output, 1 bit, high whenever the state is not IDLE.
- REQ-011: The port `done` SHALL be an output, 1 bit: a single-cycle pulse that is high while `result` is updated.
- REQ-012: The port `result` SHALL be an output, NBITS bits: the last completed conversion, held until the next `done`.

Function
- REQ-013: The FSM SHALL have the states IDLE, SAMPLE, COMP and DONE, and all outputs SHALL be driven directly from flops, with no combinational path to the gate enables.
- REQ-014: In IDLE, a `start` of 1 SHALL move the FSM to SAMPLE on the next edge; in any other state, `start` SHALL be ignored.
- REQ-015: On entry to SAMPLE, `dac_state` SHALL be set to 1<<(NBITS-1), the sample counter cleared, and `en_sample` held at 1 for exactly SAMPLE_CYC cycles.
- REQ-016: After SAMPLE_CYC cycles, the FSM SHALL move to COMP with `bit_idx` = NBITS-1, and `en_sample` SHALL fall on the same edge that `en_comp` rises.
- REQ-017: In COMP, `en_comp` SHALL be 1 for exactly NBITS cycles, and `comp_in` SHALL be sampled on the final edge of each trial cycle.
- REQ-018: At each COMP edge, bit[`bit_idx`] SHALL be cleared if `comp_in` is 0 and kept if it is 1; if `bit_idx` is greater than 0, bit[`bit_idx`-1] SHALL be set and `bit_idx` decremented.
- REQ-019: After the bit 0 decision, the FSM SHALL move to DONE, `result` SHALL load the final word, and `done` SHALL be 1 for one cycle.
- REQ-020: With `start` high in cycle 0, `done` SHALL be high in cycle SAMPLE_CYC+NBITS+1.
- REQ-021: From DONE, the FSM SHALL return to IDLE, except as stated in REQ-026.
- REQ-022: `en_sample` and `en_comp` SHALL never both be 1 in the same cycle.

Reset
- REQ-023: `rst` SHALL be sampled only on the `clk` rising edge, never asynchronously.
- REQ-024: While `rst` is 1, the FSM SHALL be in IDLE, and `en_sample`, `en_comp`, `busy`, `done`, `dac_state`, `bit_idx` and `result` SHALL all be 0.
- REQ-025: A reset asserted mid-conversion SHALL abort the conversion without a `done` pulse, and after release the block SHALL accept `start` on the first cycle.

Configuration
- REQ-026: When SAR_SEQ_CONT_EN is defined, DONE SHALL move directly to SAMPLE if `start` is 1 in the DONE cycle, giving back-to-back conversions with a period of SAMPLE_CYC+NBITS+1; when undefined, DONE SHALL always move to IDLE, giving a period of SAMPLE_CYC+NBITS+2.

Structure
- REQ-027: The package sar_seq_pkg SHALL hold the state enum typedef (IDLE, SAMPLE, COMP, DONE) and the width constants derived from NBITS and SAMPLE_CYC.
- REQ-028: The trial-word datapath (REQ-018) SHALL be the sub-module sar_reg, with inputs init, step, `comp_in` and `bit_idx`; the FSM and counters SHALL stay in sar_seq.
- REQ-029: Elaboration SHALL fail if NBITS or SAMPLE_CYC is outside its legal range.

Verification
- REQ-030: With NBITS=8, SAMPLE_CYC=2, a comparator model with target 0xA5 and `start` pulsed in cycle 0, the bench SHALL see `result`=0xA5 and `done` high in cycle 11 only, with `en_sample` high in cycles 1-2 and `en_comp` high in cycles 3-10.
- REQ-031: With `comp_in` held at 1 the bench SHALL see `result`=0xFF, and with `comp_in` held at 0 `result`=0x00; `dac_state` SHALL start at 0x80 in both cases.
- REQ-032: With `start` pulsed in cycle 5 of a conversion, the bench SHALL see no effect: a single `done`, and `busy` low in cycle 12.
- REQ-033: With `rst` asserted in cycle 6 (COMP), the bench SHALL see all outputs 0 at the next edge, no `done`, and a fresh conversion accepted right after release.
- REQ-034: With SAR_SEQ_CONT_EN defined and `start` held high, the bench SHALL see `done` pulses every 11 cycles; with the macro undefined, every 12 cycles.
- REQ-035: An assertion SHALL check across all scenarios that `en_sample` and `en_comp` are never both high and that both are glitch-free, i.e. they change only at `clk` edges.
